mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- SIZE, 32, datapath width
- TIMEOUT, 15, maximum cycles waited in REQ or RESP before bus error
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- CLK, in, 1, single clock; all state updates on rising edge
- RST, in, 1, reset; synchronous, active-high
- RegWriteM / MemToRegM / MemWriteM, in, 1 each, M-stage control from the EX/MEM register
- WA3M, in, 5, destination register
- ALUOutM, in, SIZE, effective address or ALU result
- WriteDataM, in, SIZE, store data
- CtrlM, in, 7, [2:0] access size: 000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu; [6:3] unused
- mem_req / mem_we, out, 1 each, memory request / write enable
- mem_addr, out, SIZE, word address: ALUOutM with [1:0] forced to 0
- mem_wdata, out, SIZE, lane-replicated store data
- mem_be, out, 4, byte enables
- mem_gnt / mem_rvalid, in, 1 each, request accepted / read data valid
- mem_rdata, in, SIZE, read word
- StallM, out, 1, freeze IF/ID/EX/M stages
- RegWriteW / MemToRegW, out, 1 each, registered W-stage control
- WA3W, out, 5, registered destination
- ALUOutW / ReadDataW, out, SIZE each, registered ALU result / extended load data
- MisalignM / BusErrM, out, 1 each, one-cycle exception pulses

Function
REQ-003 SHALL implement FSM IDLE, REQ, RESP, DONE.
REQ-004 Access = MemWriteM|MemToRegM; aligned = (byte) or (half and addr[0]=0) or (word and addr[1:0]=0).
REQ-005 IDLE, no access: StallM=0; W registers capture M inputs every cycle (ReadDataW=0).
REQ-006 IDLE, aligned access: StallM=1, next state REQ.
REQ-007 IDLE, misaligned access: no request; MisalignM=1 for one cycle; W capture with RegWriteW=0; StallM=0.
REQ-008 REQ: mem_req=1; addr/we/be/wdata stable until mem_gnt. On mem_gnt, store -> DONE, load -> RESP.
REQ-009 RESP: mem_req=0; on mem_rvalid, capture extracted load data into an internal holding register; -> DONE.
REQ-010 DONE: StallM=0; W registers capture M inputs (and load data for loads); -> IDLE.
REQ-011 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; mem_we=MemWriteM.
REQ-012 mem_wdata: byte {4{WriteDataM[7:0]}}; half {2{WriteDataM[15:0]}}; word WriteDataM.
REQ-013 Load extract: shift mem_rdata right by 8*addr[1:0]; lb/lh sign-extend; lbu/lhu zero-extend; lw unchanged.
REQ-014 Timeout counter SHALL clear on entering REQ/RESP and increment each cycle there. At TIMEOUT: BusErrM=1 for one cycle, mem_req=0, -> DONE with RegWriteW=0.
REQ-015 StallM SHALL be 1 in IDLE (aligned access), REQ and RESP; 0 otherwise.
REQ-016 Best-case latency: store 2 stall cycles (gnt in first REQ cycle); load 3 (gnt, then rvalid next cycle).
REQ-017 mem_rvalid outside RESP and mem_gnt outside REQ SHALL be ignored.
REQ-018 Simultaneous mem_gnt and timeout expiry SHALL treat gnt as winning.

Reset
REQ-019 While RST=1 at a rising edge: state=IDLE, counter=0, every registered output 0. Combinational outputs follow IDLE decode.
REQ-020 RST mid-transaction SHALL abandon it with no W write; mem_req=0 in the first cycle after reset.

Structure
REQ-021 Shared package mem_pkg SHALL hold the state enum, CtrlM size encodings, and the TIMEOUT default.
REQ-022 One sub-module, load_extend (combinational shift plus extension), SHALL be instantiated once.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- sw addr 0x100, data 0xDEADBEEF, immediate gnt -> be=1111, wdata=0xDEADBEEF, StallM 2 cycles, RegWriteW=0.
- lb addr 0x103, rdata 0x80FF_FF_FF -> ReadDataW=0xFFFFFF80; lbu -> 0x00000080.
- sh addr 0x102, data 0x1234 -> be=1100, wdata=0x12341234.
- lw addr 0x101 -> MisalignM pulse, mem_req stays 0, RegWriteW=0, StallM=0.
- lw with gnt held low 15 cycles -> BusErrM pulse at cycle 15, FSM returns to IDLE via DONE.
- RST asserted during RESP -> all outputs 0 next cycle; later rvalid ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and encodings for the memory access unit
package mem_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  // Access width derived from CtrlM[1:0]
  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // CtrlM[2:0] size encodings
  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 15;

  // Unlisted encodings fall back to a full-word access
  function automatic acc_size_e ctrl_size(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return (off[0] == 1'b0);
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane shift and sign/zero extension of a loaded word
module load_extend
  import mem_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      ctrl,
  output logic [SIZE-1:0] data
);

  logic [SIZE-1:0] shifted;

  assign shifted = rdata >> {byte_off, 3'b000};

  // Pick the addressed lane and extend it to the full datapath width
  always_comb begin
    data = shifted;
    case (ctrl)
      CTRL_B:  data = {{(SIZE-8){shifted[7]}}, shifted[7:0]};
      CTRL_H:  data = {{(SIZE-16){shifted[15]}}, shifted[15:0]};
      CTRL_BU: data = {{(SIZE-8){1'b0}}, shifted[7:0]};
      CTRL_HU: data = {{(SIZE-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage data memory access FSM with W-stage registers
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RegWriteM,
  input  logic            MemToRegM,
  input  logic            MemWriteM,
  input  logic [4:0]      WA3M,
  input  logic [SIZE-1:0] ALUOutM,
  input  logic [SIZE-1:0] WriteDataM,
  input  logic [6:0]      CtrlM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [SIZE-1:0] mem_rdata,
  output logic            StallM,
  output logic            RegWriteW,
  output logic            MemToRegW,
  output logic [4:0]      WA3W,
  output logic [SIZE-1:0] ALUOutW,
  output logic [SIZE-1:0] ReadDataW,
  output logic            MisalignM,
  output logic            BusErrM
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] load_data_q, load_data_d;
  logic            reg_write_w_q, reg_write_w_d;
  logic            mem_to_reg_w_q, mem_to_reg_w_d;
  logic [4:0]      wa3_w_q, wa3_w_d;
  logic [SIZE-1:0] alu_out_w_q, alu_out_w_d;
  logic [SIZE-1:0] read_data_w_q, read_data_w_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic            access;
  logic            aligned;
  logic [1:0]      byte_off;
  acc_size_e       acc_size;
  logic [3:0]      be_raw;
  logic [SIZE-1:0] wdata_raw;
  logic [SIZE-1:0] ext_data;
  logic            in_req;
  logic            last_cycle;
  logic            unused_ctrl;

  assign unused_ctrl = ^CtrlM[6:3];

  assign access     = MemWriteM | MemToRegM;
  assign byte_off   = ALUOutM[1:0];
  assign acc_size   = ctrl_size(CtrlM[2:0]);
  assign aligned    = is_aligned(acc_size, byte_off);
  assign in_req     = (state_q == ST_REQ);
  assign last_cycle = (cnt_q == CW'(TIMEOUT - 1));

  load_extend #(.SIZE(SIZE)) u_load_extend (
    .rdata    (mem_rdata),
    .byte_off (byte_off),
    .ctrl     (CtrlM[2:0]),
    .data     (ext_data)
  );

  // Byte enables and lane-replicated store data for the current access width
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = WriteDataM;
    case (acc_size)
      SZ_BYTE: begin
        be_raw    = 4'b0001 << byte_off;
        wdata_raw = {(SIZE/8){WriteDataM[7:0]}};
      end
      SZ_HALF: begin
        be_raw    = 4'b0011 << {byte_off[1], 1'b0};
        wdata_raw = {(SIZE/16){WriteDataM[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = WriteDataM;
      end
    endcase
  end

  // Bus request fields are only driven while a request is outstanding
  assign mem_req   = in_req;
  assign mem_we    = in_req & MemWriteM;
  assign mem_addr  = in_req ? {ALUOutM[SIZE-1:2], 2'b00} : '0;
  assign mem_wdata = in_req ? wdata_raw : '0;
  assign mem_be    = in_req ? be_raw : 4'b0000;

  assign StallM = ((state_q == ST_IDLE) & access & aligned) |
                  (state_q == ST_REQ) | (state_q == ST_RESP);

  // Next-state, timeout counter and W-stage capture decisions
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_data_d    = load_data_q;
    reg_write_w_d  = reg_write_w_q;
    mem_to_reg_w_d = mem_to_reg_w_q;
    wa3_w_d        = wa3_w_q;
    alu_out_w_d    = alu_out_w_q;
    read_data_w_d  = read_data_w_q;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!access || !aligned) begin
          // Pass-through; a misaligned access retires as a non-writing bubble
          reg_write_w_d  = RegWriteM & ~access;
          mem_to_reg_w_d = MemToRegM;
          wa3_w_d        = WA3M;
          alu_out_w_d    = ALUOutM;
          read_data_w_d  = '0;
          misalign_d     = access;
        end else begin
          // W sees bubbles while the access is in flight
          reg_write_w_d  = 1'b0;
          mem_to_reg_w_d = 1'b0;
          cnt_d          = '0;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        // A grant in the final allowed cycle still wins over the timeout
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = MemWriteM ? ST_DONE : ST_RESP;
        end else if (last_cycle) begin
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        if (mem_rvalid) begin
          load_data_d = ext_data;
          state_d     = ST_DONE;
        end else if (last_cycle) begin
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // DONE: retire the access; a bus error suppresses the register write
        reg_write_w_d  = RegWriteM & ~bus_err_q;
        mem_to_reg_w_d = MemToRegM;
        wa3_w_d        = WA3M;
        alu_out_w_d    = ALUOutM;
        read_data_w_d  = (MemToRegM && !bus_err_q) ? load_data_q : '0;
        state_d        = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      load_data_q    <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      wa3_w_q        <= '0;
      alu_out_w_q    <= '0;
      read_data_w_q  <= '0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      load_data_q    <= load_data_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      wa3_w_q        <= wa3_w_d;
      alu_out_w_q    <= alu_out_w_d;
      read_data_w_q  <= read_data_w_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign RegWriteW = reg_write_w_q;
  assign MemToRegW = mem_to_reg_w_q;
  assign WA3W      = wa3_w_q;
  assign ALUOutW   = alu_out_w_q;
  assign ReadDataW = read_data_w_q;
  assign MisalignM = misalign_q;
  assign BusErrM   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        CLK;
  logic        RST;
  logic        RegWriteM, MemToRegM, MemWriteM;
  logic [4:0]  WA3M;
  logic [31:0] ALUOutM, WriteDataM;
  logic [6:0]  CtrlM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        StallM, RegWriteW, MemToRegW;
  logic [4:0]  WA3W;
  logic [31:0] ALUOutW, ReadDataW;
  logic        MisalignM, BusErrM;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.SIZE(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .WA3M(WA3M), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .CtrlM(CtrlM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .WA3W(WA3W), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive_bubble();
    RegWriteM  = 1'b0;
    MemToRegM  = 1'b0;
    MemWriteM  = 1'b0;
    WA3M       = 5'd0;
    ALUOutM    = 32'd0;
    WriteDataM = 32'd0;
    CtrlM      = 7'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  // One memory instruction through the unit, with a memory model that grants
  // on request cycle gd and returns data rdl cycles after the grant.
  task automatic run_access(input bit st, input logic [2:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int gd, input int rdl,
                            input bit rw, input logic [4:0] wa);
    int          nbytes, lane, estall, ereq, stalls, reqs, resp_idx;
    bit          misal, eerr, granted, finished;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr, eload, v, ewd_got;
    nbytes = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    lane   = int'(addr % 4);
    misal  = (addr % nbytes) != 0;
    eaddr  = addr - (addr % 4);
    ebe    = 4'(((1 << nbytes) - 1) << ((nbytes == 4) ? 0 : lane));
    ewd    = (nbytes == 1) ? wd[7:0] * 32'h0101_0101 :
             (nbytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    v      = rd >> (8 * lane);
    case (ctrl)
      3'b000:  eload = 32'(int'(byte'(v[7:0])));
      3'b001:  eload = 32'(int'(shortint'(v[15:0])));
      3'b100:  eload = v % 256;
      3'b101:  eload = v % 65536;
      default: eload = v;
    endcase
    eerr   = (gd >= TO) || (!st && rdl >= TO);
    ereq   = (gd >= TO) ? TO : gd + 1;
    estall = 1 + ereq + ((st || gd >= TO) ? 0 : ((rdl >= TO) ? TO : rdl + 1));

    RegWriteM  = rw;
    MemToRegM  = !st;
    MemWriteM  = st;
    WA3M       = wa;
    ALUOutM    = addr;
    WriteDataM = wd;
    CtrlM      = {4'($urandom), ctrl};
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;

    if (misal) begin
      n_checks++;
      if (StallM !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_nostall: StallM=%b mem_req=%b required 0/0", StallM, mem_req);
      end
      @(posedge CLK); #1;
      n_checks++;
      if ({MisalignM, RegWriteW, BusErrM, WA3W, ALUOutW, ReadDataW} !==
          {1'b1, 1'b0, 1'b0, wa, addr, 32'd0}) begin
        n_fail++;
        $display("FAIL misalign_w: Mis=%b RW=%b BE=%b WA=%0d ALU=%h RD=%h required 1 0 0 %0d %h 0",
                 MisalignM, RegWriteW, BusErrM, WA3W, ALUOutW, ReadDataW, wa, addr);
      end
      drive_bubble();
      @(posedge CLK); #1;
      n_checks++;
      if (MisalignM !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_pulse: MisalignM=%b required 0 on second cycle", MisalignM);
      end
      return;
    end

    stalls = 0; reqs = 0; resp_idx = 0; granted = 0; finished = 0;
    for (int c = 0; c < 100 && !finished; c++) begin
      if (StallM === 1'b1) begin
        stalls++;
        if (mem_req === 1'b1) begin
          n_checks++;
          ewd_got = mem_wdata;
          if ({mem_addr, mem_be, mem_we} !== {eaddr, ebe, st} || (st && ewd_got !== ewd)) begin
            n_fail++;
            $display("FAIL req_fields: addr=%h be=%b we=%b wdata=%h required %h %b %b %h",
                     mem_addr, mem_be, mem_we, mem_wdata, eaddr, ebe, st, ewd);
          end
          mem_gnt    = (reqs == gd);
          mem_rvalid = 1'($urandom);
          mem_rdata  = $urandom;
          if (reqs == gd) granted = 1;
          reqs++;
        end else if (granted && !st) begin
          mem_rvalid = (resp_idx == rdl);
          mem_rdata  = (resp_idx == rdl) ? rd : $urandom;
          resp_idx++;
        end
        @(posedge CLK); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else begin
        finished = 1;
      end
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL access_budget: StallM still %b after 100 cycles, required 0", StallM);
    end
    n_checks++;
    if (stalls != estall || reqs != ereq) begin
      n_fail++;
      $display("FAIL latency: stalls=%0d reqs=%0d required %0d %0d", stalls, reqs, estall, ereq);
    end
    n_checks++;
    if (BusErrM !== eerr || MisalignM !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags: BusErrM=%b MisalignM=%b mem_req=%b required %b 0 0",
               BusErrM, MisalignM, mem_req, eerr);
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({RegWriteW, MemToRegW, WA3W, ALUOutW, BusErrM} !==
        {rw & ~eerr, ~st, wa, addr, 1'b0}) begin
      n_fail++;
      $display("FAIL w_ctrl: RW=%b M2R=%b WA=%0d ALU=%h BE=%b required %b %b %0d %h 0",
               RegWriteW, MemToRegW, WA3W, ALUOutW, BusErrM, rw & ~eerr, ~st, wa, addr);
    end
    n_checks++;
    if (ReadDataW !== ((!st && !eerr) ? eload : 32'd0)) begin
      n_fail++;
      $display("FAIL read_data: ReadDataW=%h required %h", ReadDataW,
               (!st && !eerr) ? eload : 32'd0);
    end
    drive_bubble();
  endtask

  task automatic test_reset();
    drive_bubble();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({RegWriteW, MemToRegW, WA3W, ALUOutW, ReadDataW, MisalignM, BusErrM,
         mem_req, mem_we, mem_be, StallM} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: RW=%b M2R=%b WA=%0d ALU=%h RD=%h Mis=%b BE=%b req=%b we=%b be=%b stall=%b required all 0",
               RegWriteW, MemToRegW, WA3W, ALUOutW, ReadDataW, MisalignM, BusErrM,
               mem_req, mem_we, mem_be, StallM);
    end
    RST = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [4:0]  wa;
    logic [31:0] alu;
    logic        rw;
    for (int i = 0; i < 6; i++) begin
      wa = 5'($urandom); alu = $urandom; rw = 1'($urandom);
      drive_bubble();
      RegWriteM = rw; WA3M = wa; ALUOutM = alu; WriteDataM = $urandom;
      CtrlM = 7'($urandom);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
      #1;
      n_checks++;
      if (StallM !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL pass_nostall: StallM=%b mem_req=%b required 0 0", StallM, mem_req);
      end
      @(posedge CLK); #1;
      n_checks++;
      if ({RegWriteW, MemToRegW, WA3W, ALUOutW, ReadDataW} !== {rw, 1'b0, wa, alu, 32'd0}) begin
        n_fail++;
        $display("FAIL pass_w: RW=%b M2R=%b WA=%0d ALU=%h RD=%h required %b 0 %0d %h 0",
                 RegWriteW, MemToRegW, WA3W, ALUOutW, ReadDataW, rw, wa, alu);
      end
    end
    drive_bubble();
  endtask

  task automatic test_directed();
    run_access(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 5'd0);
    run_access(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 1, 5'd7);
    run_access(0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 1, 5'd8);
    run_access(1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 0, 0, 0, 5'd0);
    run_access(0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1, 5'd9);
  endtask

  task automatic test_timeout();
    run_access(0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, TO, 0, 1, 5'd3);
    run_access(0, 3'b010, 32'h204, 32'h0, 32'h1357_9BDF, TO - 1, 0, 1, 5'd4);
    run_access(0, 3'b001, 32'h206, 32'h0, 32'h8001_0000, 0, TO + 5, 1, 5'd5);
    run_access(1, 3'b000, 32'h20B, 32'hA5, 32'h0, TO, 0, 0, 5'd0);
  endtask

  task automatic test_reset_mid_resp();
    drive_bubble();
    RegWriteM = 1'b1; MemToRegM = 1'b1; WA3M = 5'd12; ALUOutM = 32'h300;
    CtrlM = 7'b0000010;
    #1;
    @(posedge CLK); #1;
    mem_gnt = mem_req;
    @(posedge CLK); #1;
    mem_gnt = 1'b0;
    n_checks++;
    if (StallM !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_reached: StallM=%b mem_req=%b required 1 0", StallM, mem_req);
    end
    drive_bubble();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_checks++;
    if ({RegWriteW, MemToRegW, WA3W, ALUOutW, ReadDataW, MisalignM, BusErrM,
         mem_req, mem_we, mem_be, mem_addr, StallM} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: RW=%b RD=%h req=%b stall=%b addr=%h required all 0",
               RegWriteW, ReadDataW, mem_req, StallM, mem_addr);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    mem_rvalid = 1'b0;
    n_checks++;
    if ({RegWriteW, ReadDataW, mem_req, StallM, BusErrM} !== '0) begin
      n_fail++;
      $display("FAIL late_rvalid: RW=%b RD=%h req=%b stall=%b BE=%b required all 0",
               RegWriteW, ReadDataW, mem_req, StallM, BusErrM);
    end
  endtask

  task automatic test_random();
    logic [2:0] ld_ctrls [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit         st;
    logic [2:0] ctrl;
    for (int i = 0; i < 40; i++) begin
      st   = 1'($urandom);
      ctrl = st ? ld_ctrls[$urandom_range(0, 2)] : ld_ctrls[$urandom_range(0, 4)];
      run_access(st, ctrl, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 st ? 1'b0 : 1'($urandom), 5'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_access(1, 3'b000, 32'h401, 32'h0000_00C3, 32'h0, 0, 0, 0, 5'd0);
    run_access(0, 3'b101, 32'h402, 32'h0, 32'hBEEF_0000, 0, 0, 1, 5'd20);
    run_access(0, 3'b001, 32'h403, 32'h0, 32'h0, 0, 0, 1, 5'd21);
    run_access(0, 3'b001, 32'h402, 32'h0, 32'hBEEF_0000, 1, 2, 1, 5'd22);
  endtask

  initial begin
    RST = 1'b1;
    drive_bubble();
    test_reset();
    test_passthrough();
    test_directed();
    test_timeout();
    test_reset_mid_resp();
    test_back_to_back();
    test_random();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
